// File: rtl/field_row_collapse.sv
// Line-clear engine: snapshots a field, finds the full rows, optionally flashes them,
// then removes one full row per cycle (bottom-most first) and reports the cleared count.
module field_row_collapse #(
  parameter int ROW_CNT      = 20,
  parameter int COL_CNT      = 10,
  parameter int COLOR_W      = 3,
  parameter int FLASH_CYCLES = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 start_i,
  input  logic [ROW_CNT*COL_CNT*COLOR_W-1:0]   field_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [ROW_CNT*COL_CNT*COLOR_W-1:0]   field_o,
  output logic [$clog2(ROW_CNT+1)-1:0]         lines_cnt_o,
  output logic [ROW_CNT-1:0]                   flash_rows_o
);

  localparam int ROW_W = COL_CNT * COLOR_W;
  localparam int FW    = ROW_CNT * ROW_W;
  localparam int LCW   = $clog2(ROW_CNT + 1);
  localparam int RIW   = $clog2(ROW_CNT);
  localparam int FCW   = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [ROW_CNT-1:0] ROW_ONE = {{(ROW_CNT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, SCAN, FLASH, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [FW-1:0]      work;
  logic [LCW-1:0]     lines_cnt;
  logic [FCW-1:0]     flash_cnt;
  logic [ROW_CNT-1:0] full_rows;
  logic [LCW-1:0]     row_sum;
  logic [RIW-1:0]     top_full;
  logic               last_full;
  logic [FW-1:0]      collapsed;

  always_comb begin
    full_rows = '0;
    for (int r = 0; r < ROW_CNT; r++) begin
      full_rows[r] = 1'b1;
      for (int c = 0; c < COL_CNT; c++) begin
        if (work[(r*COL_CNT+c)*COLOR_W +: COLOR_W] == '0) full_rows[r] = 1'b0;
      end
    end
  end

  // top_full ends up as the highest-index (bottom-most) full row
  always_comb begin
    row_sum  = '0;
    top_full = '0;
    for (int r = 0; r < ROW_CNT; r++) begin
      row_sum = row_sum + LCW'(full_rows[r]);
      if (full_rows[r]) top_full = RIW'(r);
    end
    last_full = ((full_rows & (full_rows - ROW_ONE)) == '0);
  end

  always_comb begin
    collapsed = work;
    collapsed[ROW_W-1:0] = '0;
    for (int r = 1; r < ROW_CNT; r++) begin
      if (RIW'(r) <= top_full) collapsed[r*ROW_W +: ROW_W] = work[(r-1)*ROW_W +: ROW_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // SHIFT leaves as the last full row is removed so the collapse costs exactly N cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = SCAN;
      SCAN: begin
        if (full_rows == '0)       state_nxt = DONE;
        else if (FLASH_CYCLES > 0) state_nxt = FLASH;
        else                       state_nxt = SHIFT;
      end
      FLASH:   if (flash_cnt == '0) state_nxt = SHIFT;
      SHIFT:   if ((full_rows == '0) || last_full) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      work      <= '0;
      lines_cnt <= '0;
      flash_cnt <= '0;
    end else begin
      case (state)
        IDLE:  if (start_i) work <= field_i;
        SCAN: begin
          lines_cnt <= row_sum;
          if (FLASH_CYCLES > 0) flash_cnt <= FCW'(FLASH_CYCLES - 1);
        end
        FLASH: if (flash_cnt != '0) flash_cnt <= flash_cnt - FCW'(1);
        SHIFT: if (full_rows != '0) work <= collapsed;
        default: ;
      endcase
    end
  end

  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign field_o      = work;
  assign lines_cnt_o  = lines_cnt;
  assign flash_rows_o = (state == FLASH) ? full_rows : '0;

endmodule
